// File: rtl/pwm_pkg.sv
// Shared types for the UART-controlled PWM bank: command opcodes, parser
// states and the byte-count helper used to size multi-byte fields.
package pwm_pkg;

  typedef enum logic [1:0] {
    CMD_SET_DUTY = 2'd0,
    CMD_SET_MASK = 2'd1,
    CMD_ALL_OFF  = 2'd2,
    CMD_SET_ALL  = 2'd3
  } pwm_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DUTY_DATA = 2'd1,
    ST_MASK_DATA = 2'd2,
    ST_ALL_DATA  = 2'd3
  } pwm_parse_e;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int bytes_for(input int width);
    return (width + 7) / 8;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler dividing clk by max(div,1) and a free-running
// PWM counter, plus a registered pulse marking the first cycle of each period.
module pwm_timebase #(
  parameter int PWM_BITS  = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [PWM_BITS-1:0]  cnt,
  output logic                 period_start
);

  logic [DIV_WIDTH-1:0] pre;
  logic [DIV_WIDTH-1:0] pre_n;
  logic [DIV_WIDTH-1:0] div_last;
  logic [PWM_BITS-1:0]  cnt_n;
  logic                 tick;

  // ">=" makes a shrinking div wrap at once instead of running up to overflow.
  always_comb begin
    div_last = (div == '0) ? '0 : div - 1'b1;
    tick     = (pre >= div_last);
    pre_n    = tick ? '0 : pre + 1'b1;
    cnt_n    = tick ? cnt + 1'b1 : cnt;
  end

  // period_start is computed from the next-state values so that it is a clean
  // register output that is high exactly while cnt == 0 and pre == 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      pre          <= pre_n;
      cnt          <= cnt_n;
      period_start <= (pre_n == '0) && (cnt_n == '0);
    end
  end

endmodule

// File: rtl/uart_pwm_bank.sv
// Multi-channel PWM driver programmed by a byte command stream from the UART
// receiver: parser, shadowed duty registers, enable mask and comparators.
module uart_pwm_bank
  import pwm_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int PWM_BITS    = 8,
  parameter int DIV_WIDTH   = 8,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic [DIV_WIDTH-1:0] div,
  output logic [N_CH-1:0]      pwm_o,
  output logic                 cmd_done,
  output logic                 cmd_err,
  output logic                 period_start,
  output logic [1:0]           state_o
);

  localparam int DUTY_BYTES = bytes_for(PWM_BITS);
  localparam int MASK_BYTES = bytes_for(N_CH);
  localparam int ACC_W      = 8 * ((DUTY_BYTES > MASK_BYTES) ? DUTY_BYTES : MASK_BYTES);
  localparam int TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [2:0] DUTY_LAST = 3'(DUTY_BYTES - 1);
  localparam logic [2:0] MASK_LAST = 3'(MASK_BYTES - 1);

  // rx_valid is a one-cycle strobe with no back-pressure: every strobe carries
  // a byte that is consumed on that same clock edge.

  pwm_parse_e          state, state_n;
  logic [2:0]          idx, idx_n;
  logic [ACC_W-1:0]    acc, acc_n, acc_byte;
  logic [4:0]          ch, ch_n;
  logic [TW-1:0]       tmo, tmo_n;
  logic                done_n, err_n;
  logic                wr_duty, wr_all, wr_mask, clr_mask;
  logic [N_CH-1:0]     en;
  logic [N_CH-1:0]     cmp;
  logic [PWM_BITS-1:0] cnt;
  logic                unused_bits;

  assign unused_bits = rx_data[7];
  assign state_o     = state;

  pwm_timebase #(
    .PWM_BITS  (PWM_BITS),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timebase (
    .clk          (clk),
    .reset_n      (reset_n),
    .div          (div),
    .cnt          (cnt),
    .period_start (period_start)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    acc_n    = acc;
    ch_n     = ch;
    tmo_n    = tmo;
    done_n   = 1'b0;
    err_n    = 1'b0;
    wr_duty  = 1'b0;
    wr_all   = 1'b0;
    wr_mask  = 1'b0;
    clr_mask = 1'b0;
    // Bytes arrive LSB first; each one is merged at its byte position.
    acc_byte = acc | (ACC_W'(rx_data) << {idx, 3'b000});
    unique case (state)
      ST_IDLE: begin
        idx_n = '0;
        acc_n = '0;
        tmo_n = '0;
        if (rx_valid) begin
          ch_n = rx_data[4:0];
          unique case (pwm_cmd_e'(rx_data[6:5]))
            CMD_SET_DUTY: state_n = ST_DUTY_DATA;
            CMD_SET_MASK: state_n = ST_MASK_DATA;
            CMD_ALL_OFF: begin
              clr_mask = 1'b1;
              done_n   = 1'b1;
            end
            CMD_SET_ALL:  state_n = ST_ALL_DATA;
          endcase
        end
      end
      default: begin
        if (rx_valid) begin
          tmo_n = '0;
          acc_n = acc_byte;
          idx_n = idx + 3'd1;
          if (idx == ((state == ST_MASK_DATA) ? MASK_LAST : DUTY_LAST)) begin
            state_n = ST_IDLE;
            if (state == ST_MASK_DATA) begin
              wr_mask = 1'b1;
              done_n  = 1'b1;
            end else if (state == ST_ALL_DATA) begin
              wr_all = 1'b1;
              done_n = 1'b1;
            end else if ({1'b0, ch} < 6'(N_CH)) begin
              wr_duty = 1'b1;
              done_n  = 1'b1;
            end else begin
              err_n = 1'b1;
            end
          end
        end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end else begin
          tmo_n = tmo + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx      <= '0;
      acc      <= '0;
      ch       <= '0;
      tmo      <= '0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      en       <= '0;
      pwm_o    <= '0;
    end else begin
      idx      <= idx_n;
      acc      <= acc_n;
      ch       <= ch_n;
      tmo      <= tmo_n;
      cmd_done <= done_n;
      cmd_err  <= err_n;
      if (clr_mask)     en <= '0;
      else if (wr_mask) en <= acc_byte[N_CH-1:0];
      pwm_o    <= en & cmp;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [PWM_BITS-1:0] shadow;
    logic [PWM_BITS-1:0] active;
    logic [PWM_BITS-1:0] duty_cur;

    // A shadow write in the period_start cycle lands next period: active
    // samples the pre-write shadow value on this edge.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow <= '0;
        active <= '0;
      end else begin
        if (period_start) active <= shadow;
        if (wr_all || (wr_duty && ch == 5'(c))) shadow <= acc_byte[PWM_BITS-1:0];
      end
    end

    // The period's first compare already uses the duty being transferred.
    assign duty_cur = period_start ? shadow : active;
    assign cmp[c]   = (cnt < duty_cur) || (&duty_cur);
  end

endmodule

// File: tb/tb_uart_pwm_bank.sv
// Directed bench for uart_pwm_bank: command parsing, PWM duty/period shape,
// shadowed duty update, bad channel, timeout and mid-command reset.
module tb_uart_pwm_bank;

  localparam int N_CH        = 8;
  localparam int PWM_BITS    = 8;
  localparam int DIV_WIDTH   = 8;
  localparam int TIMEOUT_CYC = 200;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 rx_valid = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic [DIV_WIDTH-1:0] div = 8'd4;
  logic [N_CH-1:0]      pwm_o;
  logic                 cmd_done;
  logic                 cmd_err;
  logic                 period_start;
  logic [1:0]           state_o;

  int n_tests  = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int ps_gap   = 0;
  int hi       = 0;
  int other    = 0;

  always #5 clk = ~clk;

  uart_pwm_bank #(
    .N_CH        (N_CH),
    .PWM_BITS    (PWM_BITS),
    .DIV_WIDTH   (DIV_WIDTH),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .div          (div),
    .pwm_o        (pwm_o),
    .cmd_done     (cmd_done),
    .cmd_err      (cmd_err),
    .period_start (period_start),
    .state_o      (state_o)
  );

  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (cmd_err)  err_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_ps(input string tag);
    logic seen;
    seen   = 1'b0;
    ps_gap = 0;
    for (int k = 1; k <= 3000; k++) begin
      tick();
      if (period_start) begin
        seen   = 1'b1;
        ps_gap = k;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic window(input int cycles, input int bitn);
    logic [N_CH-1:0] m;
    m     = N_CH'(1) << bitn;
    hi    = 0;
    other = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (pwm_o[bitn]) hi++;
      if ((pwm_o & ~m) != '0) other++;
    end
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_pwm", 32'(pwm_o), 32'h0);
    check("rst_done", 32'(cmd_done), 32'h0);
    check("rst_err", 32'(cmd_err), 32'h0);
    check("rst_ps", 32'(period_start), 32'h0);
    check("rst_state", 32'(state_o), 32'h0);
    reset_n = 1'b1;
    tick();

    // SET_DUTY ch1 = 64, mask = 0x02, div = 4
    send(8'h01);
    check("duty_state", 32'(state_o), 32'h1);
    send(8'h40);
    check("duty_done", 32'(cmd_done), 32'h1);
    check("duty_idle", 32'(state_o), 32'h0);
    send(8'h20);
    check("mask_state", 32'(state_o), 32'h2);
    send(8'h02);
    check("mask_done", 32'(cmd_done), 32'h1);
    wait_ps("ps1_seen");
    check("done_cnt2", 32'(done_cnt), 32'd2);
    window(1024, 1);
    check("ch1_high", 32'(hi), 32'd256);
    check("ch1_others", 32'(other), 32'd0);
    check("ps_period", 32'(period_start), 32'h1);

    // SET_ALL 0xFF with full mask, then ALL_OFF
    send(8'h20);
    send(8'hFF);
    send(8'h60);
    send(8'hFF);
    check("all_done", 32'(cmd_done), 32'h1);
    wait_ps("ps2_seen");
    hi = 0;
    for (int i = 0; i < 1024; i++) begin
      tick();
      if (pwm_o != 8'hFF) hi++;
    end
    check("all_low_cycles", 32'(hi), 32'd0);
    send(8'h40);
    check("off_done", 32'(cmd_done), 32'h1);
    check("off_lag1", 32'(pwm_o), 32'hFF);
    tick();
    check("off_lag2", 32'(pwm_o), 32'h00);

    // Glitch-free duty change 200 -> 10 in the middle of a period
    send(8'h20);
    send(8'h01);
    send(8'h00);
    send(8'hC8);
    wait_ps("ps3_seen");
    hi = 0;
    for (int i = 1; i <= 1024; i++) begin
      if (i == 198) begin
        rx_valid = 1'b1;
        rx_data  = 8'h00;
      end else if (i == 199) begin
        rx_data = 8'h0A;
      end else if (i == 200) begin
        rx_valid = 1'b0;
      end
      tick();
      if (pwm_o[0]) hi++;
    end
    check("glitch_old", 32'(hi), 32'd800);
    check("glitch_ps", 32'(period_start), 32'h1);
    window(1024, 0);
    check("glitch_new", 32'(hi), 32'd40);
    check("glitch_others", 32'(other), 32'd0);

    // Channel index out of range
    send(8'h1F);
    check("bad_state", 32'(state_o), 32'h1);
    send(8'h33);
    check("bad_err", 32'(cmd_err), 32'h1);
    check("bad_done", 32'(cmd_done), 32'h0);
    check("bad_idle", 32'(state_o), 32'h0);

    // Inter-byte timeout
    send(8'h02);
    check("tmo_state", 32'(state_o), 32'h1);
    repeat (TIMEOUT_CYC - 1) tick();
    check("tmo_early_err", 32'(cmd_err), 32'h0);
    check("tmo_early_state", 32'(state_o), 32'h1);
    tick();
    check("tmo_err", 32'(cmd_err), 32'h1);
    check("tmo_idle", 32'(state_o), 32'h0);
    send(8'h02);
    send(8'h80);
    check("tmo_after_done", 32'(cmd_done), 32'h1);
    send(8'h20);
    send(8'h04);
    wait_ps("ps4_seen");
    window(1024, 2);
    check("ch2_high", 32'(hi), 32'd512);
    check("ch2_others", 32'(other), 32'd0);
    check("err_cnt", 32'(err_cnt), 32'd2);

    // Reset in the middle of a SET_MASK
    send(8'h20);
    check("pre_rst_state", 32'(state_o), 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_pwm", 32'(pwm_o), 32'h0);
    check("mid_rst_state", 32'(state_o), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();
    send(8'h05);
    check("post_rst_state", 32'(state_o), 32'h1);
    check("post_rst_done", 32'(cmd_done), 32'h0);
    send(8'h10);
    check("post_rst_duty_done", 32'(cmd_done), 32'h1);
    send(8'h20);
    send(8'h20);

    // div = 0 behaves as div = 1: 256-cycle period, ch5 duty 16
    div = 8'd0;
    wait_ps("ps5_seen");
    window(256, 5);
    check("div0_ch5_high", 32'(hi), 32'd16);
    check("div0_others", 32'(other), 32'd0);
    check("div0_period", 32'(period_start), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
